// File: rtl/tx_arbiter.sv
// Transmit arbiter: shares one transport between session control words and
// fixed-length voice packets read from the mic buffer. Voice packets are
// atomic once granted; ties between the two sources alternate.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing granted; evaluate control/voice eligibility
// CTL_SEND | control granted; wait for transport, then issue the word
// CTL_GAP  | one spacer cycle after a control word
// V_READ   | strobe the mic buffer for the next voice word
// V_LATCH  | capture mic_data returned by the read
// V_SEND   | wait for transport, then issue the latched voice word
// V_GAP    | spacer; loop for the next word or close out the packet
module tx_arbiter #(
    parameter int PKT_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctl_req,
    input  logic [1:0]  ctl_cmd,
    input  logic [15:0] ctl_data,
    output logic        ctl_ack,
    input  logic        voice_en,
    input  logic [7:0]  mic_count,
    output logic        mic_rd_en,
    input  logic [15:0] mic_data,
    input  logic        transportBusy,
    output logic [1:0]  cmd,
    output logic [15:0] dataOut,
    output logic        arbBusy,
    output logic [2:0]  arb_state,
    output logic [7:0]  pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CTL_SEND = 3'd1,
        S_CTL_GAP  = 3'd2,
        S_V_READ   = 3'd3,
        S_V_LATCH  = 3'd4,
        S_V_SEND   = 3'd5,
        S_V_GAP    = 3'd6
    } state_t;

    localparam logic [7:0] PKT_LEN_W   = 8'(PKT_LEN);
    localparam logic       GRANT_VOICE = 1'b0;
    localparam logic       GRANT_CTL   = 1'b1;

    state_t      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [15:0] word_q, word_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  pkt_count_q, pkt_count_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic        ctl_elig;
    logic        voice_elig;

    assign ctl_elig   = ctl_req && (ctl_cmd != 2'b00);
    assign voice_elig = voice_en && (mic_count >= PKT_LEN_W);

    // Next-state, grant decision and the transport word for the next cycle.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        word_d       = word_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        cmd_d        = 2'b00;
        data_d       = 16'h0000;
        ack_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl_elig && voice_elig) begin
                    // Tie goes to whichever source was not served last.
                    if (last_grant_q == GRANT_VOICE) begin
                        state_d = S_CTL_SEND;
                    end else begin
                        state_d    = S_V_READ;
                        word_cnt_d = PKT_LEN_W;
                    end
                end else if (ctl_elig) begin
                    state_d = S_CTL_SEND;
                end else if (voice_elig) begin
                    state_d    = S_V_READ;
                    word_cnt_d = PKT_LEN_W;
                end
            end
            S_CTL_SEND: begin
                if (!transportBusy) begin
                    cmd_d        = ctl_cmd;
                    data_d       = ctl_data;
                    ack_d        = 1'b1;
                    last_grant_d = GRANT_CTL;
                    state_d      = S_CTL_GAP;
                end
            end
            S_CTL_GAP: begin
                state_d = S_IDLE;
            end
            S_V_READ: begin
                state_d = S_V_LATCH;
            end
            S_V_LATCH: begin
                word_d  = mic_data;
                state_d = S_V_SEND;
            end
            S_V_SEND: begin
                if (!transportBusy) begin
                    cmd_d      = (word_cnt_q == 8'd1) ? 2'b11 : 2'b10;
                    data_d     = word_q;
                    word_cnt_d = word_cnt_q - 8'd1;
                    state_d    = S_V_GAP;
                end
            end
            S_V_GAP: begin
                if (word_cnt_q != 8'd0) begin
                    state_d = S_V_READ;
                end else begin
                    pkt_count_d  = pkt_count_q + 8'd1;
                    last_grant_d = GRANT_VOICE;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered transport outputs; reset abandons any packet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= 8'd0;
            word_q       <= 16'h0000;
            last_grant_q <= GRANT_VOICE;
            pkt_count_q  <= 8'd0;
            cmd_q        <= 2'b00;
            data_q       <= 16'h0000;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            word_q       <= word_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
        end
    end

    // The read strobe is decoded from state so mic_data lands in V_LATCH.
    assign mic_rd_en = (state_q == S_V_READ);
    assign cmd       = cmd_q;
    assign dataOut   = data_q;
    assign ctl_ack   = ack_q;
    assign arbBusy   = (state_q != S_IDLE);
    assign arb_state = state_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: a transaction-level model predicts the
// sequence of transport words; a monitor pops and compares each one.
module tb_tx_arbiter;

    localparam int PKT_LEN = 8;

    typedef struct packed {
        logic [1:0]  c;
        logic [15:0] d;
        logic        a;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctl_req = 1'b0;
    logic [1:0]  ctl_cmd = 2'b00;
    logic [15:0] ctl_data = 16'h0000;
    logic        ctl_ack;
    logic        voice_en = 1'b0;
    logic [7:0]  mic_count = 8'd0;
    logic        mic_rd_en;
    logic [15:0] mic_data = 16'h0000;
    logic        transportBusy = 1'b0;
    logic [1:0]  cmd;
    logic [15:0] dataOut;
    logic        arbBusy;
    logic [2:0]  arb_state;
    logic [7:0]  pkt_count;

    int n_pass = 0;
    int n_total = 0;

    exp_t        exp_q[$];
    logic [15:0] mic_q[$];
    logic [15:0] mdl_fifo[$];

    int          cyc = 0;
    int          hold_until = -1;
    int          busy_pct = 0;
    int          reads_seen = 0;
    int          words_seen = 0;
    int          ctl_issue = 0;
    int          ctl_done = 0;
    logic [1:0]  nxt_cmd = 2'b00;
    logic [15:0] nxt_data = 16'h0000;
    logic        voice_want = 1'b0;
    logic        busy_at_edge = 1'b0;
    int          gap = 100;
    exp_t        mon_e;

    int          model_pkts = 0;
    bit          model_last_ctl = 1'b0;

    tx_arbiter #(.PKT_LEN(PKT_LEN)) dut (
        .clk(clk),
        .reset(reset),
        .ctl_req(ctl_req),
        .ctl_cmd(ctl_cmd),
        .ctl_data(ctl_data),
        .ctl_ack(ctl_ack),
        .voice_en(voice_en),
        .mic_count(mic_count),
        .mic_rd_en(mic_rd_en),
        .mic_data(mic_data),
        .transportBusy(transportBusy),
        .cmd(cmd),
        .dataOut(dataOut),
        .arbBusy(arbBusy),
        .arb_state(arb_state),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Environment: mic buffer, control source and transport busy, all driven on negedge.
    always @(negedge clk) begin
        cyc++;
        if (mic_rd_en === 1'b1) begin
            reads_seen++;
            if (mic_q.size() != 0) mic_data = mic_q.pop_front();
        end
        mic_count = (mic_q.size() > 255) ? 8'd255 : 8'(mic_q.size());
        voice_en = voice_want;
        if (ctl_req && ctl_ack === 1'b1) begin
            ctl_req = 1'b0;
        end else if (!ctl_req && ctl_done != ctl_issue) begin
            ctl_req  = 1'b1;
            ctl_cmd  = nxt_cmd;
            ctl_data = nxt_data;
            ctl_done = ctl_issue;
        end
        transportBusy = (cyc <= hold_until) ? 1'b1 : ($urandom_range(0, 99) < busy_pct);
    end

    // Busy as seen by the DUT at the edge that would issue a word.
    always @(posedge clk) busy_at_edge = transportBusy;

    // Monitor: every nonzero cmd consumes one scoreboard entry.
    always @(negedge clk) begin
        if (cmd !== 2'b00) begin
            words_seen++;
            chk("word_spacing_ge2", 32'(gap >= 2), 32'd1);
            chk("busy_at_issue", 32'(busy_at_edge), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(cmd), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cmd", 32'(cmd), 32'(mon_e.c));
                chk("dataOut", 32'(dataOut), 32'(mon_e.d));
                chk("ctl_ack", 32'(ctl_ack), 32'(mon_e.a));
            end
            gap = 0;
        end else begin
            chk("idle_dataOut", 32'(dataOut), 32'd0);
            chk("idle_ctl_ack", 32'(ctl_ack), 32'd0);
            gap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load_words(input int n, input bit seq, input logic [15:0] start);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = seq ? 16'(start + 16'(i)) : 16'($urandom);
            mic_q.push_back(w);
            mdl_fifo.push_back(w);
        end
    endtask

    task automatic issue_ctl(input logic [1:0] c, input logic [15:0] d);
        nxt_cmd  = c;
        nxt_data = d;
        ctl_issue++;
    endtask

    task automatic exp_ctl(input logic [1:0] c, input logic [15:0] d);
        exp_t e;
        e.c = c;
        e.d = d;
        e.a = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic exp_voice();
        exp_t e;
        for (int i = 0; i < PKT_LEN; i++) begin
            e.c = (i == PKT_LEN - 1) ? 2'b11 : 2'b10;
            e.d = mdl_fifo.pop_front();
            e.a = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk({nm, "_words_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        voice_want = 1'b0;
        cycles(4);
    endtask

    task automatic end_checks(input string nm, input int base, input int exp_reads);
        chk({nm, "_arbBusy"}, 32'(arbBusy), 32'd0);
        chk({nm, "_pkt_count"}, 32'(pkt_count), 32'(model_pkts % 256));
        chk({nm, "_mic_reads"}, 32'(reads_seen - base), 32'(exp_reads));
    endtask

    task automatic run_phase(input int kind, input string nm);
        int base;
        int exp_reads;
        int nz;
        logic [1:0]  c;
        logic [15:0] d;
        base      = reads_seen;
        exp_reads = 0;
        busy_pct  = $urandom_range(0, 60);
        c = 2'($urandom_range(1, 3));
        d = 16'($urandom);
        case (kind)
            0: begin
                issue_ctl(c, d);
                exp_ctl(c, d);
                model_last_ctl = 1'b1;
            end
            1: begin
                load_words(PKT_LEN, 1'b0, 16'h0);
                voice_want = 1'b1;
                exp_voice();
                model_pkts++;
                model_last_ctl = 1'b0;
                exp_reads = PKT_LEN;
                if ($urandom_range(0, 1) == 1) begin
                    cycles(3);
                    voice_want = 1'b0;
                end
            end
            2: begin
                load_words(PKT_LEN, 1'b0, 16'h0);
                issue_ctl(c, d);
                voice_want = 1'b1;
                if (!model_last_ctl) begin
                    exp_ctl(c, d);
                    exp_voice();
                    model_last_ctl = 1'b0;
                end else begin
                    exp_voice();
                    exp_ctl(c, d);
                    model_last_ctl = 1'b1;
                end
                model_pkts++;
                exp_reads = PKT_LEN;
            end
            default: begin
                load_words(PKT_LEN - 1, 1'b0, 16'h0);
                voice_want = 1'b1;
                nz = 0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #2;
                    if (arbBusy !== 1'b0 || mic_rd_en !== 1'b0) nz++;
                end
                chk({nm, "_short_stays_idle"}, 32'(nz), 32'd0);
                chk({nm, "_short_no_reads"}, 32'(reads_seen - base), 32'd0);
                load_words(1, 1'b0, 16'h0);
                exp_voice();
                model_pkts++;
                model_last_ctl = 1'b0;
                exp_reads = PKT_LEN;
            end
        endcase
        drain(nm);
        end_checks(nm, base, exp_reads);
    endtask

    initial begin
        int base;
        int t;
        int nz;
        logic [15:0] first_w;

        reset = 1'b0;
        cycles(3);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_dataOut", 32'(dataOut), 32'd0);
        chk("rst_ctl_ack", 32'(ctl_ack), 32'd0);
        chk("rst_mic_rd_en", 32'(mic_rd_en), 32'd0);
        chk("rst_arbBusy", 32'(arbBusy), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b1;
        cycles(2);

        // Control word latency: issued two cycles after the request.
        busy_pct = 0;
        issue_ctl(2'b01, 16'h3005);
        exp_ctl(2'b01, 16'h3005);
        model_last_ctl = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("ctl_lat_cmd_early", 32'(cmd), 32'd0);
        chk("ctl_lat_busy", 32'(arbBusy), 32'd1);
        @(posedge clk);
        #1;
        chk("ctl_lat_cmd", 32'(cmd), 32'h1);
        chk("ctl_lat_data", 32'(dataOut), 32'h3005);
        chk("ctl_lat_ack", 32'(ctl_ack), 32'd1);
        drain("ctl_first");
        end_checks("ctl_first", reads_seen, 0);

        // Voice packet with words 1..8.
        base = reads_seen;
        busy_pct = 0;
        load_words(PKT_LEN, 1'b1, 16'h0001);
        voice_want = 1'b1;
        exp_voice();
        model_pkts++;
        model_last_ctl = 1'b0;
        drain("voice_seq");
        end_checks("voice_seq", base, PKT_LEN);

        // Transport busy held for 20 cycles while a word waits.
        base = reads_seen;
        busy_pct = 0;
        load_words(PKT_LEN, 1'b0, 16'h0);
        first_w = mdl_fifo[0];
        voice_want = 1'b1;
        exp_voice();
        model_pkts++;
        model_last_ctl = 1'b0;
        t = 0;
        while (reads_seen == base && t < 50) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("hold_first_read", 32'(reads_seen - base), 32'd1);
        hold_until = cyc + 20;
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (cmd !== 2'b00) nz++;
        end
        chk("hold_cmd_idle", 32'(nz), 32'd0);
        chk("hold_no_extra_read", 32'(reads_seen - base), 32'd1);
        @(posedge clk);
        #1;
        chk("hold_release_cmd", 32'(cmd), 32'h2);
        chk("hold_release_data", 32'(dataOut), 32'(first_w));
        drain("hold");
        end_checks("hold", base, PKT_LEN);

        // Occupancy one short of a packet, then topped up.
        run_phase(3, "short");

        for (int p = 0; p < 40; p++) begin
            run_phase(int'($urandom_range(0, 3)), "rand");
        end

        // Reset after the third word of a packet.
        busy_pct = 20;
        base = words_seen;
        load_words(PKT_LEN, 1'b0, 16'h0);
        voice_want = 1'b1;
        exp_voice();
        t = 0;
        while (words_seen - base < 3 && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("rst_mid_third_word", 32'(words_seen - base), 32'd3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_cmd", 32'(cmd), 32'd0);
        chk("rst_mid_dataOut", 32'(dataOut), 32'd0);
        chk("rst_mid_ctl_ack", 32'(ctl_ack), 32'd0);
        chk("rst_mid_mic_rd_en", 32'(mic_rd_en), 32'd0);
        chk("rst_mid_arbBusy", 32'(arbBusy), 32'd0);
        chk("rst_mid_pkt_count", 32'(pkt_count), 32'd0);
        exp_q.delete();
        mic_q.delete();
        mdl_fifo.delete();
        voice_want = 1'b0;
        model_pkts = 0;
        model_last_ctl = 1'b0;
        reset = 1'b1;
        cycles(3);

        // Both eligible straight out of reset, with a second control word
        // raised while the voice packet is in flight.
        base = reads_seen;
        busy_pct = 15;
        load_words(PKT_LEN, 1'b1, 16'h0101);
        issue_ctl(2'b01, 16'hC001);
        voice_want = 1'b1;
        exp_ctl(2'b01, 16'hC001);
        exp_voice();
        exp_ctl(2'b10, 16'hC002);
        model_pkts++;
        model_last_ctl = 1'b1;
        t = 0;
        while (exp_q.size() > PKT_LEN + 1 && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("tie_ctl_first", 32'(exp_q.size()), 32'(PKT_LEN + 1));
        issue_ctl(2'b10, 16'hC002);
        drain("tie");
        end_checks("tie", base, PKT_LEN);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter PKT_LEN, default 8: 16-bit voice words per voice packet, legal range 1..255.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-low; 0 at a rising clk edge resets the block.
REQ-004 ctl_req  in  1  session control word pending; level, held until ctl_ack.
REQ-005 ctl_cmd  in  2  control command; 2'b00 means no request even with ctl_req=1.
REQ-006 ctl_data  in  16  control payload, stable while ctl_req=1.
REQ-007 ctl_ack  out  1  one-cycle pulse in the cycle the control word is issued.
REQ-008 voice_en  in  1  enables voice packet scheduling.
REQ-009 mic_count  in  8  mic buffer occupancy in words.
REQ-010 mic_rd_en  out  1  one-cycle read strobe to the mic buffer.
REQ-011 mic_data  in  16  mic buffer output, valid the cycle after mic_rd_en.
REQ-012 transportBusy  in  1  transport cannot accept a word while 1.
REQ-013 cmd  out  2  transport command; 2'b00 idle, nonzero for exactly one cycle per word.
REQ-014 dataOut  out  16  word accompanying cmd; 0 when cmd=2'b00.
REQ-015 arbBusy  out  1  1 whenever state is not IDLE.
REQ-016 arb_state  out  3  current state encoding for debug.
REQ-017 pkt_count  out  8  completed voice packets, wraps 255->0.

Function
REQ-018 States: IDLE, CTL_SEND, CTL_GAP, V_READ, V_LATCH, V_SEND, V_GAP.
REQ-019 Control eligible: ctl_req=1 and ctl_cmd!=2'b00; voice eligible: voice_en=1 and mic_count>=PKT_LEN.
REQ-020 IDLE grant: only one eligible -> grant it; both eligible -> grant opposite of last_grant; neither -> stay IDLE.
REQ-021 Control grant: IDLE->CTL_SEND; voice grant: IDLE->V_READ with word counter loaded to PKT_LEN.
REQ-022 CTL_SEND: while transportBusy=1 hold with cmd=00; else cmd=ctl_cmd, dataOut=ctl_data, ctl_ack=1 for that cycle, last_grant<=control, go to CTL_GAP.
REQ-023 CTL_GAP: one cycle, cmd=00, then IDLE; a ctl_req still high is treated as a new word.
REQ-024 V_READ: mic_rd_en=1 for one cycle, go to V_LATCH.
REQ-025 V_LATCH: register mic_data, go to V_SEND.
REQ-026 V_SEND: while transportBusy=1 hold; else issue latched word with cmd=2'b10, or 2'b11 if it is the last word of the packet; decrement counter; go to V_GAP.
REQ-027 V_GAP: one cycle; counter>0 -> V_READ, else pkt_count+1, last_grant<=voice, IDLE.
REQ-028 Packets are atomic: no control word is issued between the first and last word of a voice packet.
REQ-029 voice_en or mic_count falling mid-packet does not abort the packet.
REQ-030 Exactly PKT_LEN mic_rd_en pulses and PKT_LEN nonzero cmd cycles per voice packet.
REQ-031 transportBusy held high indefinitely -> remain in the send state; no strobes issued.
REQ-032 Minimum two cycles between consecutive nonzero cmd cycles.

Reset
REQ-033 On reset=0: state IDLE; cmd=00, dataOut=0, ctl_ack=0, mic_rd_en=0, arbBusy=0, arb_state=IDLE encoding, pkt_count=0, counter=0, last_grant=voice (control wins first tie).
REQ-034 Reset mid-packet abandons the packet; pkt_count is not incremented; outputs take reset values after that edge.

Verification
REQ-035 ctl_req=1, ctl_cmd=01, ctl_data=16'h3005, transportBusy=0 -> cmd=01, dataOut=16'h3005, ctl_ack=1 two cycles after req (one cycle after IDLE grant).
REQ-036 voice_en=1, mic_count=8, mic_data incrementing 1..8 -> eight mic_rd_en pulses; words 1..7 with cmd=10, word 8 with cmd=11; pkt_count=1.
REQ-037 mic_count=7, voice_en=1 -> no mic_rd_en, arbBusy=0; raising to 8 starts packet.
REQ-038 Control and voice both eligible from reset -> control word first, then full voice packet, then the next pending control word.
REQ-039 transportBusy=1 for 20 cycles during V_SEND -> cmd=00 throughout, word issued the first cycle busy=0, no extra mic_rd_en.
REQ-040 reset=0 after 3rd word of a packet -> all outputs at reset values next edge; pkt_count=0; new packet restarts at word 1.
